// File: rtl/regfile_sb.sv
// Register file with NUM_RD combinational read ports, two write ports and a per-register busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data and busy clears onto the read ports.
module regfile_sb #(
   parameter int NUM_REG   = 16,
   parameter int SEL_WIDTH = 4,
   parameter int D_WIDTH   = 34,
   parameter int NUM_RD    = 2,
   parameter int ZERO_REG  = 1
) (
   input  logic                          clk,
   input  logic                          rst_i,
   input  logic                          wen0_i,
   input  logic [SEL_WIDTH-1:0]          wa0_i,
   input  logic [D_WIDTH-1:0]            wd0_i,
   input  logic                          wen1_i,
   input  logic [SEL_WIDTH-1:0]          wa1_i,
   input  logic [D_WIDTH-1:0]            wd1_i,
   input  logic                          claim_i,
   input  logic [SEL_WIDTH-1:0]          claim_a_i,
   input  logic [NUM_RD*SEL_WIDTH-1:0]   ra_i,
   output logic [NUM_RD*D_WIDTH-1:0]     rd_o,
   output logic [NUM_RD-1:0]             rbusy_o,
   output logic                          busy_any_o
);

   logic [D_WIDTH-1:0] regs [NUM_REG];
   logic [NUM_REG-1:0] busy;

   // Port 0 data wins on a shared address; only port 1 (long-latency writeback) clears busy,
   // and a same-cycle claim wins over that clear because a new producer is in flight.
   always_ff @(posedge clk) begin
      if (rst_i) begin
         for (int r = 0; r < NUM_REG; r++) begin
            regs[r] <= '0;
         end
         busy <= '0;
      end else begin
         for (int r = 0; r < NUM_REG; r++) begin
            if (ZERO_REG == 0 || r != 0) begin
               if (wen0_i && wa0_i == SEL_WIDTH'(r)) begin
                  regs[r] <= wd0_i;
               end else if (wen1_i && wa1_i == SEL_WIDTH'(r)) begin
                  regs[r] <= wd1_i;
               end
               if (claim_i && claim_a_i == SEL_WIDTH'(r)) begin
                  busy[r] <= 1'b1;
               end else if (wen1_i && wa1_i == SEL_WIDTH'(r)) begin
                  busy[r] <= 1'b0;
               end
            end
         end
      end
   end

   assign busy_any_o = |busy;

   genvar k;
   generate
      for (k = 0; k < NUM_RD; k++) begin : g_rd
         logic [SEL_WIDTH-1:0] addr;
         logic [D_WIDTH-1:0]   val;
         logic                 bsy;
         logic                 hit;

         assign addr = ra_i[k*SEL_WIDTH +: SEL_WIDTH];

         // Out-of-range addresses and a hard-wired zero register never hit, so they read 0 / not busy.
         always_comb begin
            hit = 1'b0;
            val = '0;
            bsy = 1'b0;
            for (int r = 0; r < NUM_REG; r++) begin
               if (addr == SEL_WIDTH'(r) && (ZERO_REG == 0 || r != 0)) begin
                  hit = 1'b1;
                  val = regs[r];
                  bsy = busy[r];
               end
            end
`ifdef REGFILE_BYPASS_EN
            if (hit) begin
               if (wen1_i && wa1_i == addr) begin
                  val = wd1_i;
                  if (!(claim_i && claim_a_i == addr)) begin
                     bsy = 1'b0;
                  end
               end
               if (wen0_i && wa0_i == addr) begin
                  val = wd0_i;
               end
            end
`endif
         end

         assign rd_o[k*D_WIDTH +: D_WIDTH] = val;
         assign rbusy_o[k]                 = bsy;
      end
   endgenerate

endmodule

// File: tb/tb_regfile_sb.sv
// Randomized bench for regfile_sb: directed scenarios plus random traffic against an array-based model.
module tb_regfile_sb;
  localparam int NUM_REG   = 16;
  localparam int SEL_WIDTH = 4;
  localparam int D_WIDTH   = 34;
  localparam int NUM_RD    = 2;
  localparam int ZERO_REG  = 1;

  logic                        clk;
  logic                        rst_i;
  logic                        wen0_i, wen1_i, claim_i;
  logic [SEL_WIDTH-1:0]        wa0_i, wa1_i, claim_a_i;
  logic [D_WIDTH-1:0]          wd0_i, wd1_i;
  logic [SEL_WIDTH-1:0]        ra [NUM_RD];
  logic [NUM_RD*SEL_WIDTH-1:0] ra_i;
  logic [NUM_RD*D_WIDTH-1:0]   rd_o;
  logic [NUM_RD-1:0]           rbusy_o;
  logic                        busy_any_o;

  int checks = 0;
  int failures = 0;

  logic [D_WIDTH-1:0] m_reg [NUM_REG];
  logic               m_busy [NUM_REG];

  always_comb begin
    ra_i = '0;
    for (int k = 0; k < NUM_RD; k++) ra_i[k*SEL_WIDTH +: SEL_WIDTH] = ra[k];
  end

  regfile_sb #(
    .NUM_REG(NUM_REG), .SEL_WIDTH(SEL_WIDTH), .D_WIDTH(D_WIDTH),
    .NUM_RD(NUM_RD), .ZERO_REG(ZERO_REG)
  ) dut (
    .clk(clk), .rst_i(rst_i),
    .wen0_i(wen0_i), .wa0_i(wa0_i), .wd0_i(wd0_i),
    .wen1_i(wen1_i), .wa1_i(wa1_i), .wd1_i(wd1_i),
    .claim_i(claim_i), .claim_a_i(claim_a_i),
    .ra_i(ra_i), .rd_o(rd_o), .rbusy_o(rbusy_o), .busy_any_o(busy_any_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit reg_valid(input int a);
    return (a < NUM_REG) && !(ZERO_REG != 0 && a == 0);
  endfunction

  function automatic logic [D_WIDTH-1:0] exp_rd(input int a);
    logic [D_WIDTH-1:0] v;
    if (!reg_valid(a)) return '0;
    v = m_reg[a];
`ifdef REGFILE_BYPASS_EN
    if (wen0_i && int'(wa0_i) == a) v = wd0_i;
    else if (wen1_i && int'(wa1_i) == a) v = wd1_i;
`endif
    return v;
  endfunction

  function automatic logic exp_busy(input int a);
    logic b;
    if (!reg_valid(a)) return 1'b0;
    b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
    if (wen1_i && int'(wa1_i) == a && !(claim_i && int'(claim_a_i) == a)) b = 1'b0;
`endif
    return b;
  endfunction

  function automatic logic exp_any();
    logic b = 1'b0;
    for (int r = 0; r < NUM_REG; r++) b |= m_busy[r];
    return b;
  endfunction

  task automatic check_outputs();
    for (int k = 0; k < NUM_RD; k++) begin
      check($sformatf("rd%0d", k), 64'(rd_o[k*D_WIDTH +: D_WIDTH]), 64'(exp_rd(int'(ra[k]))));
      check($sformatf("rbusy%0d", k), 64'(rbusy_o[k]), 64'(exp_busy(int'(ra[k]))));
    end
    check("busy_any", 64'(busy_any_o), 64'(exp_any()));
  endtask

  // Model advance for one rising edge: writes then scoreboard rules.
  task automatic model_edge();
    if (rst_i) begin
      for (int r = 0; r < NUM_REG; r++) begin
        m_reg[r] = '0;
        m_busy[r] = 1'b0;
      end
    end else begin
      if (wen1_i && reg_valid(int'(wa1_i))) begin
        m_reg[wa1_i] = wd1_i;
        m_busy[wa1_i] = 1'b0;
      end
      if (wen0_i && reg_valid(int'(wa0_i))) m_reg[wa0_i] = wd0_i;
      if (claim_i && reg_valid(int'(claim_a_i))) m_busy[claim_a_i] = 1'b1;
    end
  endtask

  // driver: called at a negedge with inputs set; checks, advances one edge, returns at next negedge
  task automatic step();
    #1;
    check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    rst_i = 1'b0; wen0_i = 1'b0; wen1_i = 1'b0; claim_i = 1'b0;
    wa0_i = '0; wa1_i = '0; claim_a_i = '0; wd0_i = '0; wd1_i = '0;
  endtask

  task automatic randomize_inputs(input bit allow_rst);
    rst_i     = allow_rst && ($urandom_range(0, 49) == 0);
    wen0_i    = $urandom_range(0, 1);
    wa0_i     = SEL_WIDTH'($urandom_range(0, 15));
    wd0_i     = {2'($urandom), 32'($urandom)};
    wen1_i    = $urandom_range(0, 2) == 0;
    wa1_i     = ($urandom_range(0, 3) == 0) ? wa0_i : SEL_WIDTH'($urandom_range(0, 15));
    wd1_i     = {2'($urandom), 32'($urandom)};
    claim_i   = $urandom_range(0, 3) == 0;
    claim_a_i = ($urandom_range(0, 3) == 0) ? wa1_i : SEL_WIDTH'($urandom_range(0, 15));
    for (int k = 0; k < NUM_RD; k++) ra[k] = SEL_WIDTH'($urandom_range(0, 15));
  endtask

  initial begin
    idle();
    for (int k = 0; k < NUM_RD; k++) ra[k] = '0;
    for (int r = 0; r < NUM_REG; r++) begin
      m_reg[r] = 'x;
      m_busy[r] = 1'bx;
    end
    rst_i = 1'b1;
    @(negedge clk);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    idle();

    // 1: random traffic, then reset -> everything zero
    for (int i = 0; i < 10; i++) begin
      randomize_inputs(1'b0);
      step();
    end
    idle();
    rst_i = 1'b1;
    step();
    idle();
    for (int k = 0; k < NUM_RD; k++) ra[k] = SEL_WIDTH'(k + 3);
    #1;
    for (int k = 0; k < NUM_RD; k++) begin
      check("rst_rd", 64'(rd_o[k*D_WIDTH +: D_WIDTH]), 64'd0);
      check("rst_rbusy", 64'(rbusy_o[k]), 64'd0);
    end
    check("rst_busy_any", 64'(busy_any_o), 64'd0);
    step();

    // 2: write reg3 via port 0
    wen0_i = 1'b1; wa0_i = 4'd3; wd0_i = 34'h1_2345_6789; ra[0] = 4'd3;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("t2_same_cycle", 64'(rd_o[0 +: D_WIDTH]), 64'h1_2345_6789);
`else
    check("t2_same_cycle", 64'(rd_o[0 +: D_WIDTH]), 64'd0);
`endif
    step();
    idle();
    #1;
    check("t2_next_cycle", 64'(rd_o[0 +: D_WIDTH]), 64'h1_2345_6789);
    step();

    // 3: both ports hit reg5, port 0 wins
    wen0_i = 1'b1; wa0_i = 4'd5; wd0_i = 34'h11;
    wen1_i = 1'b1; wa1_i = 4'd5; wd1_i = 34'h22;
    step();
    idle();
    ra[0] = 4'd5;
    #1;
    check("t3_port0_wins", 64'(rd_o[0 +: D_WIDTH]), 64'h11);
    step();

    // 4: claim reg7, then port-1 writeback clears it
    claim_i = 1'b1; claim_a_i = 4'd7;
    step();
    idle();
    ra[0] = 4'd7;
    #1;
    check("t4_busy", 64'(rbusy_o[0]), 64'd1);
    check("t4_busy_any", 64'(busy_any_o), 64'd1);
    wen1_i = 1'b1; wa1_i = 4'd7; wd1_i = 34'hAA;
    step();
    idle();
    #1;
    check("t4_cleared", 64'(rbusy_o[0]), 64'd0);
    check("t4_data", 64'(rd_o[0 +: D_WIDTH]), 64'hAA);
    check("t4_busy_any_clr", 64'(busy_any_o), 64'd0);
    step();

    // 5: claim and clear of reg9 in the same cycle -> stays busy, data updated
    claim_i = 1'b1; claim_a_i = 4'd9;
    wen1_i = 1'b1; wa1_i = 4'd9; wd1_i = 34'h155;
    step();
    idle();
    ra[1] = 4'd9;
    #1;
    check("t5_busy", 64'(rbusy_o[1]), 64'd1);
    check("t5_data", 64'(rd_o[D_WIDTH +: D_WIDTH]), 64'h155);
    wen1_i = 1'b1; wa1_i = 4'd9; wd1_i = 34'h156;
    step();
    idle();

    // 6: zero register ignores writes and claims
    wen0_i = 1'b1; wa0_i = 4'd0; wd0_i = 34'h3FF;
    claim_i = 1'b1; claim_a_i = 4'd0;
    ra[0] = 4'd0; ra[1] = 4'd0;
    step();
    idle();
    #1;
    check("t6_rd", 64'(rd_o[0 +: D_WIDTH]), 64'd0);
    check("t6_rbusy", 64'(rbusy_o[0]), 64'd0);
    check("t6_busy_any", 64'(busy_any_o), 64'd0);
    step();

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      randomize_inputs(1'b1);
      step();
    end
    idle();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
